fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Run-control and branch-decode block that drives the control inputs of the instruction fetch unit (`InstFetch`). It consumes the program counter and the instruction word returned by the instruction ROM. From these it generates `Start`, `BranchAbs`, `BranchRelEn` and `Target`. It sequences a program run from a host request through to HALT or timeout, and reports completion and the run-cycle count.

## Interface

Parameters:
- `PC_W`, 10, program counter and `Target` width
- `INST_W`, 9, instruction width
- `CNT_W`, 16, cycle counter width
- `TIMEOUT`, 1000, maximum RUN cycles before forced stop (1..2^CNT_W-1)

Ports:
- `Clk`  in  1  clock, all state updates on rising edge
- `Reset`  in  1  asynchronous, active-low reset
- `Req`  in  1  host run request, level-sensitive
- `ProgCtr`  in  PC_W  current PC from `InstFetch`
- `Inst`  in  INST_W  instruction at `ProgCtr` (combinational ROM output)
- `Start`  out  1  hold PC (to `InstFetch`)
- `BranchAbs`  out  1  unconditional absolute jump (to `InstFetch`)
- `BranchRelEn`  out  1  relative jump enable; `InstFetch` gates it with `ALU_flag`
- `Target`  out  PC_W  absolute target or signed relative offset
- `Done`  out  1  run finished
- `Timeout`  out  1  run ended by timeout rather than HALT
- `CycleCnt`  out  CNT_W  RUN cycles of the current or last run
- `HaltPC`  out  PC_W  `ProgCtr` captured when the run ended

## Operation

- Instruction decode, applied only in RUN:
  - HALT: `Inst == 9'h1FF`.
  - ABS: `Inst[8:6] == 3'b110`. `Target = {Inst[5:0], 4'b0000}`, `BranchAbs = 1`.
  - REL: `Inst[8:6] == 3'b111` and not HALT. `Target` = `Inst[5:0]` sign-extended to `PC_W`, `BranchRelEn = 1`.
  - Anything else: no branch, `Target = 0`.
- FSM states are IDLE, LAUNCH, RUN and DONE. Reset enters IDLE.
- IDLE:
  - Outputs: `Start=1`, branches 0, `Target=0`, `Done=0`.
  - `Req=1` moves to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - Outputs: `Start=0`, `BranchAbs=1`, `Target=0`, so the PC becomes 0 at the next edge.
  - Clears `CycleCnt`, `Timeout` and `HaltPC` to 0.
  - Always moves to RUN.
- RUN:
  - Outputs: `Start=0`; the branch outputs are decoded combinationally from `Inst`.
  - `CycleCnt` increments every RUN cycle, including the exit cycle.
  - Exit on HALT: `Start=1` and both branch outputs 0 in that cycle, so the PC freezes at the HALT address. Move to DONE.
  - Exit on timeout: when `CycleCnt == TIMEOUT-1` and `Inst` is not HALT, set `Start=1`, branches 0, `Timeout<=1`, and move to DONE.
  - On either exit, `HaltPC <= ProgCtr`.
  - HALT takes priority over timeout in the same cycle (`Timeout` stays 0).
- DONE:
  - Outputs: `Start=1`, `Done=1`. `CycleCnt`, `Timeout` and `HaltPC` hold.
  - `Req=0` moves to IDLE. While `Req` stays 1, the block remains in DONE (no auto-restart).
- `Req` deasserted during LAUNCH or RUN is ignored; the run always completes.
- Relative target arithmetic: `InstFetch` computes `ProgCtr + Target` modulo 2^PC_W, so a negative offset wraps. The sequencer performs no range check.

## Timing

- Reset values: FSM=IDLE, `Start=1`, `BranchAbs=0`, `BranchRelEn=0`, `Target=0`, `Done=0`, `Timeout=0`, `CycleCnt=0`, `HaltPC=0`.
- A reset asserted in any state forces these values immediately (asynchronously), including mid-run.
- Request to execution:
  - `Req` is sampled at edge N.
  - LAUNCH occupies cycle N+1.
  - The first RUN cycle is N+2, with `ProgCtr=0`.
- Branch outputs are combinational from `Inst` within the same cycle; `InstFetch` applies them at the next edge. There are no bubbles between instructions.
- Completion latency:
  - HALT seen in RUN cycle k gives `Done=1` from cycle k+1.
  - `CycleCnt` equals the number of RUN cycles: the HALT instruction's position plus 1 for straight-line code.
- `Done` falls one cycle after `Req` is sampled low.
- On a timeout exit, `CycleCnt` equals `TIMEOUT` and `Timeout=1`.

## Test plan

- **Reset:** assert `Reset=0` mid-RUN with `CycleCnt=5` → all outputs return to their reset values immediately. After `Reset=1`, the block idles with `Start=1` until `Req`.
- **Straight line:** ROM has 0x000 at addresses 0–3 and 0x1FF at address 4; pulse `Req` → LAUNCH drives `BranchAbs=1`, `Target=0`; PC steps 0,1,2,3,4; `Done=1`, `CycleCnt=5`, `HaltPC=4`, `Timeout=0`.
- **Absolute branch:** `Inst=9'h185` at address 1 → `BranchAbs=1`, `Target=10'h050`; the next PC is 0x050. HALT placed at 0x050 gives `HaltPC=0x050`.
- **Relative branch:** `Inst=9'h1FE` (offset -2) at address 6 → `BranchRelEn=1`, `Target=10'h3FE`. With `ALU_flag=1` the PC becomes 4; with `ALU_flag=0` it becomes 7.
- **Timeout:** `TIMEOUT=8`, with a relative offset of 0 at address 0 and `ALU_flag=1` (infinite loop) → `Done=1`, `Timeout=1`, `CycleCnt=8`, `HaltPC=0`.
- **Handshake:** hold `Req=1` after `Done` → stays in DONE with `Start=1`. Drop `Req` → the next cycle is IDLE with `Done=0`. Re-raise `Req` → LAUNCH clears `CycleCnt` and `Timeout`.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Run-control and branch decode for the instruction fetch unit. A host
// request launches a program run from PC 0. The block then decodes absolute
// and relative branches from the ROM word while running. A run ends on HALT
// or after TIMEOUT run cycles, and the block then reports the cycle count and
// the PC where the run stopped.

module fetch_sequencer #(
    parameter int PC_W    = 10,
    parameter int INST_W  = 9,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic [PC_W-1:0]   ProgCtr,
    input  logic [INST_W-1:0] Inst,
    output logic              Start,
    output logic              BranchAbs,
    output logic              BranchRelEn,
    output logic [PC_W-1:0]   Target,
    output logic              Done,
    output logic              Timeout,
    output logic [CNT_W-1:0]  CycleCnt,
    output logic [PC_W-1:0]   HaltPC
);

    // Run-control states. LAUNCH forces PC to 0 for exactly one cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter value in the last permitted RUN cycle.
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TIMEOUT - 1);
    localparam logic [INST_W-1:0] HALT_INST = '1;
    localparam logic [2:0]        OP_ABS    = 3'b110;
    localparam logic [2:0]        OP_REL    = 3'b111;

    state_t state, state_next;

    // Instruction decode. This is valid in any state, but it is only used in RUN.
    logic            is_halt;
    logic            is_abs;
    logic            is_rel;
    logic            timeout_hit;
    logic            run_exit;
    logic [PC_W-1:0] abs_target;
    logic [PC_W-1:0] rel_target;

    assign is_halt     = (Inst == HALT_INST);
    assign is_abs      = (Inst[8:6] == OP_ABS);
    // The all-ones word shares the REL opcode. HALT wins.
    assign is_rel      = (Inst[8:6] == OP_REL) && !is_halt;
    assign abs_target  = PC_W'({Inst[5:0], 4'b0000});
    // The 6-bit offset is sign-extended. InstFetch adds it modulo 2^PC_W.
    assign rel_target  = PC_W'($signed(Inst[5:0]));
    assign timeout_hit = (CycleCnt == LAST_CNT);
    assign run_exit    = is_halt || timeout_hit;

    // State register. Reset forces IDLE at any time, including mid-run.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every
            // always_ff then samples pre-edge values regardless of ordering.
            state <= state_next;
        end
    end

    // Next-state and Moore/Mealy outputs. The fetch controls depend on Inst in RUN.
    always_comb begin
        // NOTE: every output and the next state get a default first. Any path
        // that does not assign them then cannot infer a latch.
        state_next  = state;
        Start       = 1'b1;
        BranchAbs   = 1'b0;
        BranchRelEn = 1'b0;
        Target      = '0;
        Done        = 1'b0;

        unique case (state)
            IDLE: begin
                if (Req) begin
                    state_next = LAUNCH;
                end
            end

            LAUNCH: begin
                // An absolute jump to 0 makes the first RUN cycle see PC 0.
                Start      = 1'b0;
                BranchAbs  = 1'b1;
                state_next = RUN;
            end

            RUN: begin
                if (run_exit) begin
                    // Start stays high with no branch, so the PC freezes where the run ended.
                    state_next = DONE;
                end else begin
                    Start       = 1'b0;
                    BranchAbs   = is_abs;
                    BranchRelEn = is_rel;
                    if (is_abs) begin
                        Target = abs_target;
                    end else if (is_rel) begin
                        Target = rel_target;
                    end
                end
            end

            DONE: begin
                Done = 1'b1;
                // Req must drop before another run can begin.
                if (!Req) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Run bookkeeping. LAUNCH clears, RUN counts, exit captures, DONE holds.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            CycleCnt <= '0;
            Timeout  <= 1'b0;
            HaltPC   <= '0;
        end else begin
            case (state)
                LAUNCH: begin
                    CycleCnt <= '0;
                    Timeout  <= 1'b0;
                    HaltPC   <= '0;
                end

                RUN: begin
                    // The exit cycle counts as a RUN cycle.
                    CycleCnt <= CycleCnt + CNT_W'(1);
                    if (run_exit) begin
                        HaltPC  <= ProgCtr;
                        // HALT in the timeout cycle is a normal completion.
                        Timeout <= !is_halt;
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer. A behavioural InstFetch and ROM surround the
// DUT. An architectural program model predicts the PC trace, the branch
// controls and the run results for directed and random programs.

module tb_fetch_sequencer;

    localparam int PC_W   = 10;
    localparam int INST_W = 9;
    localparam int CNT_W  = 16;
    localparam int TMO    = 12;
    localparam int ROM_N  = 1 << PC_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              alu_flag;
    logic [PC_W-1:0]   prog_ctr = 10'h123;
    logic [INST_W-1:0] inst;
    logic              start;
    logic              branch_abs;
    logic              branch_rel_en;
    logic [PC_W-1:0]   target;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [PC_W-1:0]   halt_pc;

    logic [INST_W-1:0] rom [ROM_N];
    bit                flags [TMO];
    int                exp_pc [$];

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .PC_W(PC_W), .INST_W(INST_W), .CNT_W(CNT_W), .TIMEOUT(TMO)
    ) dut (
        .Clk(clk), .Reset(reset), .Req(req), .ProgCtr(prog_ctr), .Inst(inst),
        .Start(start), .BranchAbs(branch_abs), .BranchRelEn(branch_rel_en),
        .Target(target), .Done(done), .Timeout(timeout),
        .CycleCnt(cycle_cnt), .HaltPC(halt_pc)
    );

    always #5 clk = ~clk;

    // Combinational instruction ROM
    assign inst = rom[prog_ctr];

    // Behavioural InstFetch
    always @(posedge clk) begin
        if (!start) begin
            if (branch_abs)                     prog_ctr <= target;
            else if (branch_rel_en && alu_flag) prog_ctr <= prog_ctr + target;
            else                                prog_ctr <= prog_ctr + 10'd1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int offset6(input logic [5:0] f);
        return f[5] ? int'(f) - 64 : int'(f);
    endfunction

    // Architectural execution: one instruction per RUN cycle from PC 0
    function automatic void ref_run(output int n, output int hpc, output bit to);
        int pc;
        logic [INST_W-1:0] w;
        exp_pc.delete();
        pc = 0;
        n  = 0;
        to = 1'b0;
        while (1) begin
            exp_pc.push_back(pc);
            n++;
            w = rom[pc];
            if (w == 9'h1FF) break;
            if (n == TMO) begin to = 1'b1; break; end
            if (w[8:6] == 3'b110)                     pc = int'(w[5:0]) * 16;
            else if (w[8:6] == 3'b111 && flags[n-1])  pc = (pc + offset6(w[5:0])) & (ROM_N - 1);
            else                                      pc = (pc + 1) & (ROM_N - 1);
        end
        hpc = pc;
    endfunction

    task automatic fill_rom(input logic [INST_W-1:0] v);
        for (int a = 0; a < ROM_N; a++) rom[a] = v;
    endtask

    task automatic set_flags(input bit v);
        for (int i = 0; i < TMO; i++) flags[i] = v;
    endtask

    task automatic do_run(input string tag);
        int n, hpc;
        bit to;
        logic [INST_W-1:0] w;
        ref_run(n, hpc, to);
        @(negedge clk);
        req = 1'b1;
        alu_flag = 1'b0;
        @(negedge clk);
        check({tag, ".launch_start"}, 32'(start), 0);
        check({tag, ".launch_abs"}, 32'(branch_abs), 1);
        check({tag, ".launch_rel"}, 32'(branch_rel_en), 0);
        check({tag, ".launch_tgt"}, 32'(target), 0);
        check({tag, ".launch_done"}, 32'(done), 0);
        req = 1'($urandom_range(0, 1));
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            alu_flag = flags[c];
            w = rom[exp_pc[c]];
            check({tag, ".pc"}, 32'(prog_ctr), exp_pc[c]);
            check({tag, ".cnt"}, 32'(cycle_cnt), c);
            check({tag, ".run_done"}, 32'(done), 0);
            if (c == 0) begin
                check({tag, ".clr_timeout"}, 32'(timeout), 0);
                check({tag, ".clr_haltpc"}, 32'(halt_pc), 0);
            end
            if (c == n - 1) begin
                check({tag, ".exit_start"}, 32'(start), 1);
                check({tag, ".exit_abs"}, 32'(branch_abs), 0);
                check({tag, ".exit_rel"}, 32'(branch_rel_en), 0);
            end else begin
                check({tag, ".run_start"}, 32'(start), 0);
                check({tag, ".dec_abs"}, 32'(branch_abs), (w[8:6] == 3'b110) ? 1 : 0);
                check({tag, ".dec_rel"}, 32'(branch_rel_en), (w[8:6] == 3'b111) ? 1 : 0);
                if (w[8:6] == 3'b110)      check({tag, ".dec_tgt"}, 32'(target), int'(w[5:0]) * 16);
                else if (w[8:6] == 3'b111) check({tag, ".dec_tgt"}, 32'(target), offset6(w[5:0]) & (ROM_N - 1));
                else                       check({tag, ".dec_tgt"}, 32'(target), 0);
            end
            req = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check({tag, ".done"}, 32'(done), 1);
        check({tag, ".done_start"}, 32'(start), 1);
        check({tag, ".cyclecnt"}, 32'(cycle_cnt), n);
        check({tag, ".haltpc"}, 32'(halt_pc), hpc);
        check({tag, ".timeout"}, 32'(timeout), to ? 1 : 0);
        req = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check({tag, ".hold_done"}, 32'(done), 1);
            check({tag, ".hold_start"}, 32'(start), 1);
            check({tag, ".hold_cnt"}, 32'(cycle_cnt), n);
        end
        req = 1'b0;
        @(negedge clk);
        check({tag, ".idle_done"}, 32'(done), 0);
        check({tag, ".idle_start"}, 32'(start), 1);
        check({tag, ".idle_abs"}, 32'(branch_abs), 0);
        check({tag, ".idle_tgt"}, 32'(target), 0);
    endtask

    initial begin
        int r;
        reset    = 1'b0;
        req      = 1'b0;
        alu_flag = 1'b0;
        fill_rom(9'h000);
        set_flags(1'b0);
        #12;
        check("rst.start", 32'(start), 1);
        check("rst.abs", 32'(branch_abs), 0);
        check("rst.rel", 32'(branch_rel_en), 0);
        check("rst.tgt", 32'(target), 0);
        check("rst.done", 32'(done), 0);
        check("rst.timeout", 32'(timeout), 0);
        check("rst.cnt", 32'(cycle_cnt), 0);
        check("rst.haltpc", 32'(halt_pc), 0);
        @(negedge clk);
        reset = 1'b1;

        // Straight-line code, HALT at address 4
        fill_rom(9'h000); rom[4] = 9'h1FF; set_flags(1'b0);
        do_run("straight");

        // Absolute jump from address 1 to 0x050
        fill_rom(9'h000); rom[1] = 9'h185; rom[10'h050] = 9'h1FF;
        do_run("abs");

        // Relative -2 at address 6, taken once, then falling through
        fill_rom(9'h000); rom[6] = 9'h1FE; rom[7] = 9'h1FF;
        set_flags(1'b0); flags[6] = 1'b1;
        do_run("rel_taken");
        set_flags(1'b0);
        do_run("rel_not_taken");

        // Infinite loop at 0 ends by timeout
        fill_rom(9'h000); rom[0] = 9'h1C0; set_flags(1'b1);
        do_run("timeout");

        // HALT in the same cycle as the timeout takes priority
        fill_rom(9'h000); rom[TMO-1] = 9'h1FF; set_flags(1'b0);
        do_run("halt_at_limit");

        // Negative offset wraps below 0
        fill_rom(9'h000); rom[0] = 9'h1E0; rom[992] = 9'h1FF; set_flags(1'b1);
        do_run("wrap");

        // Reset mid-run with CycleCnt=5
        fill_rom(9'h000); set_flags(1'b0);
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst.cnt_before", 32'(cycle_cnt), 5);
        reset = 1'b0;
        #1;
        check("midrst.start", 32'(start), 1);
        check("midrst.abs", 32'(branch_abs), 0);
        check("midrst.rel", 32'(branch_rel_en), 0);
        check("midrst.tgt", 32'(target), 0);
        check("midrst.done", 32'(done), 0);
        check("midrst.timeout", 32'(timeout), 0);
        check("midrst.cnt", 32'(cycle_cnt), 0);
        check("midrst.haltpc", 32'(halt_pc), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst.idle_start", 32'(start), 1);
            check("midrst.idle_done", 32'(done), 0);
            check("midrst.idle_cnt", 32'(cycle_cnt), 0);
        end

        // Random programs
        for (int t = 0; t < 40; t++) begin
            for (int a = 0; a < ROM_N; a++) begin
                r = $urandom_range(0, 9);
                if (r <= 4)      rom[a] = 9'($urandom_range(0, 9'h17F));
                else if (r <= 6) rom[a] = {3'b110, 6'($urandom_range(0, 63))};
                else if (r <= 8) rom[a] = {3'b111, 6'($urandom_range(0, 63))};
                else             rom[a] = 9'h1FF;
            end
            for (int i = 0; i < TMO; i++) flags[i] = 1'($urandom_range(0, 1));
            do_run("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
